wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Arbitrates the single register-file write port between two writeback sources: the in-order pipeline writeback stream (P) and a long-latency unit stream (L), such as a divider or multicycle load.
- Grants at most one source per cycle and registers the winner.
- Drives the regfile write port, the ID-stage forwarding bundle and the debug trace.
- Fixed priority to P, with a starvation counter that guarantees L progress.

Parameters:
- STARVE_LIMIT, 4: number of consecutive cycles L may lose before it wins over P. Legal range 0..15; 0 means L always wins a tie.
- CNT_W, 4: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- p_valid  input  1  P has a writeback request
- p_ready  output  1  P request granted this cycle
- p_we  input  1  P register write enable
- p_waddr  input  5  P destination register
- p_wdata  input  32  P write data
- p_pc  input  32  P instruction PC
- l_valid  input  1  L has a writeback request
- l_ready  output  1  L request granted this cycle
- l_we  input  1  L register write enable
- l_waddr  input  5  L destination register
- l_wdata  input  32  L write data
- l_pc  input  32  L instruction PC
- rf_we  output  1  regfile write enable
- rf_waddr  output  5  regfile write address
- rf_wdata  output  32  regfile write data
- wb_rf_zip  output  38  forwarding bundle {rf_we, rf_waddr, rf_wdata} to ID
- debug_wb_pc  output  32  PC of the retiring write
- debug_wb_rf_we  output  4  {4{rf_we}}
- wb_src  output  1  source of the current output: 0 = P, 1 = L

Behaviour:
- Grant (combinational):
  - Only p_valid: grant P. Only l_valid: grant L.
  - Both valid: grant L iff starve_cnt >= STARVE_LIMIT, else grant P.
  - Neither valid: no grant.
- p_ready/l_ready equal the respective grant.
  - Depend only on valids and starve_cnt, never on payload.
  - Never both 1.
  - A source holds valid and payload stable until its ready is 1; transfer happens on valid & ready.
- Output register, 1-cycle latency:
  - On a grant, latch {we, waddr, wdata, pc, src} of the winner and set out_valid <= 1.
  - With no grant, out_valid <= 0 and the payload regs hold.
- Output derivation:
  - rf_we = out_valid & out_we & (out_waddr != 0); writes to r0 are suppressed.
  - rf_waddr, rf_wdata, debug_wb_pc and wb_src come directly from the payload regs.
  - debug_wb_rf_we = {4{rf_we}}.
- Starvation counter (CNT_W bits):
  - Cleared when L is granted or l_valid = 0.
  - Incremented when l_valid = 1 and P is granted, saturating at STARVE_LIMIT.
- No internal buffering and no back-pressure on the regfile port: the write always completes in the output cycle.
- Simultaneous same-destination requests are not reordered or merged. The later-granted write overwrites the earlier; ordering is the issuing logic's responsibility.
- Reset (synchronous), dominates any simultaneous grant:
  - out_valid = 0, all payload regs = 0, starve_cnt = 0.
  - Hence rf_we = 0, debug_wb_rf_we = 0, wb_rf_zip = 0, wb_src = 0, debug_wb_pc = 0.
  - p_ready/l_ready still follow the valids combinationally during reset; sources must not present requests while reset is high.
  - A request handed over in the cycle reset asserts is dropped.

Test Plan:
- Reset then idle: hold reset 2 cycles, then all valids 0 for 3 cycles -> rf_we=0, wb_rf_zip=38'h0, debug_wb_rf_we=4'h0 throughout.
- Single P write: p_valid=1, p_we=1, p_waddr=5, p_wdata=32'hDEADBEEF, p_pc=32'h1C000010 for 1 cycle -> p_ready=1 that cycle.
  - Next cycle: rf_we=1, rf_waddr=5, rf_wdata=32'hDEADBEEF, debug_wb_pc=32'h1C000010, wb_src=0, debug_wb_rf_we=4'hF.
  - Following cycle: rf_we=0.
- r0 suppression: L request with l_we=1, l_waddr=0, l_wdata=32'h12345678 -> l_ready=1; next cycle rf_we=0, wb_src=1, debug_wb_pc=l_pc.
- Starvation, STARVE_LIMIT=4: p_valid and l_valid held 1 continuously -> p_ready=1 for cycles 0–3, l_ready=1 in cycle 4.
  - Then starve_cnt resets to 0: P wins cycles 5–8 and L wins cycle 9.
  - The outputs replay the grant sequence one cycle later.
- Back-to-back alternation: P valid only in cycle 0, L valid only in cycle 1, P valid only in cycle 2 -> rf_we=1 in cycles 1–3 with wb_src=0,1,0; no bubble.
- Reset mid-stream: assert reset in the cycle a P grant occurs -> next cycle rf_we=0 and wb_rf_zip=0, no write retired; starve_cnt reads 0 after reset.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Arbitrates the single register-file write port between the
//             in-order pipeline writeback stream (P) and a long-latency unit
//             stream (L). P has fixed priority. A starvation counter lets L
//             win a tie once it has lost STARVE_LIMIT cycles in a row. The
//             winner is registered, so the output appears one cycle after the
//             grant.
//  Ports    : clk, reset              - clock, synchronous active-high reset
//             p_* / l_*               - request streams (valid/ready handshake
//                                       carrying we, waddr, wdata, pc)
//             rf_we/rf_waddr/rf_wdata - regfile write port (r0 suppressed)
//             wb_rf_zip               - {rf_we, rf_waddr, rf_wdata} to ID
//             debug_wb_pc/_rf_we      - debug trace of the retiring write
//             wb_src                  - 0 = output came from P, 1 = from L
//  Revision : 1.0  initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    output logic        p_ready,
    input  logic        p_we,
    input  logic [4:0]  p_waddr,
    input  logic [31:0] p_wdata,
    input  logic [31:0] p_pc,
    input  logic        l_valid,
    output logic        l_ready,
    input  logic        l_we,
    input  logic [4:0]  l_waddr,
    input  logic [31:0] l_wdata,
    input  logic [31:0] l_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [37:0] wb_rf_zip,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic        wb_src
);

    localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             out_valid_q, out_valid_d;
    logic             out_we_q,    out_we_d;
    logic [4:0]       out_waddr_q, out_waddr_d;
    logic [31:0]      out_wdata_q, out_wdata_d;
    logic [31:0]      out_pc_q,    out_pc_d;
    logic             out_src_q,   out_src_d;

    logic w_p_grant;
    logic w_l_grant;

    // Grant depends only on the valids and the counter, never on payload.
    // With STARVE_LIMIT = 0 the comparison is always true, so L wins ties.
    always_comb begin
        w_l_grant = l_valid & (~p_valid | (starve_q >= C_LIMIT));
        w_p_grant = p_valid & ~w_l_grant;
    end

    assign p_ready = w_p_grant;
    assign l_ready = w_l_grant;

    always_comb begin
        starve_d    = starve_q;
        out_valid_d = 1'b0;
        out_we_d    = out_we_q;
        out_waddr_d = out_waddr_q;
        out_wdata_d = out_wdata_q;
        out_pc_d    = out_pc_q;
        out_src_d   = out_src_q;

        // L counts consecutive cycles it waited while P took the port.
        if (!l_valid || w_l_grant) begin
            starve_d = '0;
        end else if (w_p_grant && (starve_q < C_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end

        if (w_l_grant) begin
            out_valid_d = 1'b1;
            out_we_d    = l_we;
            out_waddr_d = l_waddr;
            out_wdata_d = l_wdata;
            out_pc_d    = l_pc;
            out_src_d   = 1'b1;
        end else if (w_p_grant) begin
            out_valid_d = 1'b1;
            out_we_d    = p_we;
            out_waddr_d = p_waddr;
            out_wdata_d = p_wdata;
            out_pc_d    = p_pc;
            out_src_d   = 1'b0;
        end
    end

    // Reset dominates: a request granted in the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            out_valid_q <= 1'b0;
            out_we_q    <= 1'b0;
            out_waddr_q <= 5'd0;
            out_wdata_q <= 32'd0;
            out_pc_q    <= 32'd0;
            out_src_q   <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            out_valid_q <= out_valid_d;
            out_we_q    <= out_we_d;
            out_waddr_q <= out_waddr_d;
            out_wdata_q <= out_wdata_d;
            out_pc_q    <= out_pc_d;
            out_src_q   <= out_src_d;
        end
    end

    // Writes to r0 never reach the regfile.
    assign rf_we          = out_valid_q & out_we_q & (out_waddr_q != 5'd0);
    assign rf_waddr       = out_waddr_q;
    assign rf_wdata       = out_wdata_q;
    assign wb_rf_zip      = {rf_we, rf_waddr, rf_wdata};
    assign debug_wb_pc    = out_pc_q;
    assign debug_wb_rf_we = {4{rf_we}};
    assign wb_src         = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Self-checking bench for wb_port_arbiter. Directed scenarios
//             followed by randomized traffic, all compared against a
//             behavioural model of the arbitration rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int C_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, p_we, l_valid, l_we;
    logic [4:0]  p_waddr, l_waddr;
    logic [31:0] p_wdata, p_pc, l_wdata, l_pc;
    logic        p_ready, l_ready, rf_we, wb_src;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, debug_wb_pc;
    logic [37:0] wb_rf_zip;
    logic [3:0]  debug_wb_rf_we;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: the last retired write and L's consecutive-loss count.
    logic        m_v, m_we, m_src;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_pc;
    int          losses;

    // Grant results of the most recent step, as seen by the sources.
    logic obs_p_ready, obs_l_ready;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(C_LIMIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .p_valid(p_valid), .p_ready(p_ready), .p_we(p_we), .p_waddr(p_waddr),
        .p_wdata(p_wdata), .p_pc(p_pc),
        .l_valid(l_valid), .l_ready(l_ready), .l_we(l_we), .l_waddr(l_waddr),
        .l_wdata(l_wdata), .l_pc(l_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wb_rf_zip(wb_rf_zip), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .wb_src(wb_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check readies and outputs against the model at the falling
    // edge, then advance the model on the rising edge.
    task automatic step();
        logic pg, lg, e_we;
        @(negedge clk);
        lg   = l_valid && (!p_valid || losses >= C_LIMIT);
        pg   = p_valid && !lg;
        e_we = m_v && m_we && (m_addr != 5'd0);
        obs_p_ready = p_ready;
        obs_l_ready = l_ready;
        chk("p_ready", p_ready, pg);
        chk("l_ready", l_ready, lg);
        chk("rf_we", rf_we, e_we);
        chk("rf_waddr", rf_waddr, m_addr);
        chk("rf_wdata", rf_wdata, m_data);
        chk("zip", wb_rf_zip, {e_we, m_addr, m_data});
        chk("dbg_pc", debug_wb_pc, m_pc);
        chk("dbg_we", debug_wb_rf_we, {4{e_we}});
        chk("wb_src", wb_src, m_src);
        @(posedge clk);
        if (reset) begin
            m_v = 0; m_we = 0; m_src = 0; m_addr = 0; m_data = 0; m_pc = 0;
            losses = 0;
        end else begin
            m_v = pg || lg;
            if (lg) begin
                m_we = l_we; m_addr = l_waddr; m_data = l_wdata; m_pc = l_pc; m_src = 1;
            end else if (pg) begin
                m_we = p_we; m_addr = p_waddr; m_data = p_wdata; m_pc = p_pc; m_src = 0;
            end
            if (!l_valid || lg) losses = 0;
            else if (pg) losses = (losses + 1 > C_LIMIT) ? C_LIMIT : losses + 1;
        end
        #1;
    endtask

    task automatic set_p(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] pc);
        p_valid = v; p_we = we; p_waddr = a; p_wdata = d; p_pc = pc;
    endtask

    task automatic set_l(input logic v, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic [31:0] pc);
        l_valid = v; l_we = we; l_waddr = a; l_wdata = d; l_pc = pc;
    endtask

    initial begin
        m_v = 0; m_we = 0; m_src = 0; m_addr = 0; m_data = 0; m_pc = 0;
        losses = 0;
        obs_p_ready = 0; obs_l_ready = 0;
        reset = 1;
        set_p(0, 0, 0, 0, 0);
        set_l(0, 0, 0, 0, 0);

        // Reset, then idle.
        step(); step();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_rf_we", rf_we, 0);
            chk("idle_zip", wb_rf_zip, 0);
            chk("idle_dbg_we", debug_wb_rf_we, 0);
        end

        // Single P write.
        set_p(1, 1, 5'd5, 32'hDEADBEEF, 32'h1C000010);
        step();
        chk("p1_ready", obs_p_ready, 1);
        set_p(0, 0, 0, 0, 0);
        chk("p1_rf_we", rf_we, 1);
        chk("p1_waddr", rf_waddr, 5);
        chk("p1_wdata", rf_wdata, 32'hDEADBEEF);
        chk("p1_pc", debug_wb_pc, 32'h1C000010);
        chk("p1_src", wb_src, 0);
        chk("p1_dbg_we", debug_wb_rf_we, 4'hF);
        step();
        chk("p1_after", rf_we, 0);

        // Write to r0 from L is suppressed.
        set_l(1, 1, 5'd0, 32'h12345678, 32'h1C000020);
        step();
        chk("r0_l_ready", obs_l_ready, 1);
        set_l(0, 0, 0, 0, 0);
        chk("r0_rf_we", rf_we, 0);
        chk("r0_src", wb_src, 1);
        chk("r0_pc", debug_wb_pc, 32'h1C000020);
        step();

        // Starvation: both held valid, L wins in cycles 4 and 9.
        set_p(1, 1, 5'd7, 32'hAAAA0000, 32'h1C000100);
        set_l(1, 1, 5'd9, 32'hBBBB0000, 32'h1C000200);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("starve_l", obs_l_ready, (i == 4 || i == 9));
            chk("starve_p", obs_p_ready, !(i == 4 || i == 9));
            chk("starve_src", wb_src, (i == 4 || i == 9));
        end
        set_p(0, 0, 0, 0, 0);
        set_l(0, 0, 0, 0, 0);
        step();

        // Back-to-back alternation without bubbles.
        set_p(1, 1, 5'd1, 32'h11111111, 32'h1C000300);
        step();
        chk("alt0_we", rf_we, 1); chk("alt0_src", wb_src, 0);
        set_p(0, 0, 0, 0, 0);
        set_l(1, 1, 5'd2, 32'h22222222, 32'h1C000304);
        step();
        chk("alt1_we", rf_we, 1); chk("alt1_src", wb_src, 1);
        set_l(0, 0, 0, 0, 0);
        set_p(1, 1, 5'd3, 32'h33333333, 32'h1C000308);
        step();
        chk("alt2_we", rf_we, 1); chk("alt2_src", wb_src, 0);
        set_p(0, 0, 0, 0, 0);
        step();

        // Reset mid-stream after building up L's loss count.
        set_p(1, 1, 5'd4, 32'h44444444, 32'h1C000400);
        set_l(1, 1, 5'd6, 32'h66666666, 32'h1C000404);
        step(); step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_zip", wb_rf_zip, 0);
        chk("rst_pc", debug_wb_pc, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rst_cnt_l", obs_l_ready, (i == 4));
        end
        set_p(0, 0, 0, 0, 0);
        set_l(0, 0, 0, 0, 0);
        step();

        // Randomized traffic; a source holds its request until granted.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1;
                set_p(0, 0, 0, 0, 0);
                set_l(0, 0, 0, 0, 0);
            end else begin
                reset = 0;
                if (!(p_valid && !obs_p_ready))
                    set_p($urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom_range(0, 31)),
                          $urandom, $urandom);
                if (!(l_valid && !obs_l_ready))
                    set_l($urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom_range(0, 31)),
                          $urandom, $urandom);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
